// File: rtl/dmem_lane_ctrl.sv
// Load/store front end for four byte-lane data BRAMs: lane steering, write-data rotation and load re-alignment.
// Optional macro MISALIGN_SPLIT_EN: split word-crossing accesses into two beats instead of rejecting them.
module dmem_lane_ctrl #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_data_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] lane_w_addr_o,
  output logic [ADDR_WIDTH-1:0] lane_r_addr_o,
  output logic [3:0]            lane_write_en_o,
  output logic [3:0]            lane_read_en_o,
  output logic [31:0]           lane_din_o,
  input  logic [31:0]           lane_dout_i,
  output logic                  dbg_state_o
);

  // Handshake: a request is taken on the posedge where req_valid_i && req_ready_o;
  // rsp_valid_o is a single-cycle pulse per taken request, rsp_data_o/rsp_err_o valid with it.

  localparam int WW = ADDR_WIDTH - 2;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lanes_beat1(input logic [1:0] off, input logic [2:0] n);
    logic [3:0] m;
    m = '0;
    for (int l = 0; l < 4; l++) m[l] = (l >= int'(off)) && (l < int'(off) + int'(n));
    return m;
  endfunction

  function automatic logic [31:0] rot_left(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd0:    return d;
      2'd1:    return {d[23:0], d[31:24]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[7:0], d[31:8]};
    endcase
  endfunction

  function automatic logic [31:0] rot_right(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd0:    return d;
      2'd1:    return {d[7:0], d[31:8]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[23:0], d[31:24]};
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] n, input logic sgn);
    case (n)
      3'd1:    return {{24{sgn & d[7]}}, d[7:0]};
      3'd2:    return {{16{sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  logic [2:0]    req_n;
  logic [1:0]    req_off;
  logic [WW-1:0] req_word;
  logic          req_mis;
  logic [3:0]    req_mask;
  logic [31:0]   load_now;
  logic [ADDR_WIDTH-1:0] lane_addr;

  assign req_n    = size_bytes(req_size_i);
  assign req_off  = req_addr_i[1:0];
  assign req_word = req_addr_i[ADDR_WIDTH-1:2];
  assign req_mis  = ({1'b0, req_off} + req_n) > 3'd4;
  assign req_mask = lanes_beat1(req_off, req_n);
  assign load_now = extend(rot_right(lane_dout_i, req_off), req_n, req_signed_i);

  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_err_q;

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_err_o     = rsp_err_q;
  assign lane_w_addr_o = lane_addr;
  assign lane_r_addr_o = lane_addr;

`ifdef MISALIGN_SPLIT_EN
  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

  function automatic logic [3:0] lanes_beat2(input logic [1:0] off, input logic [2:0] n);
    logic [3:0] m;
    m = '0;
    for (int l = 0; l < 4; l++) m[l] = (l + 4) < (int'(off) + int'(n));
    return m;
  endfunction

  state_t        state_q;
  logic          sv_we_q;
  logic [2:0]    sv_n_q;
  logic          sv_signed_q;
  logic [1:0]    sv_off_q;
  logic [WW-1:0] sv_word_q;
  logic [31:0]   sv_wdata_q;
  logic [31:0]   beat1_q;
  logic [WW-1:0] word_next;
  logic [3:0]    sv_mask;
  logic [31:0]   merged_d;
  logic [31:0]   load_split_d;

  assign req_ready_o = (state_q == IDLE);
  assign dbg_state_o = state_q;
  assign word_next   = sv_word_q + 1'b1;
  assign sv_mask     = lanes_beat2(sv_off_q, sv_n_q);

  // Lanes at or above the start offset were read in beat 1; the low lanes come from beat 2.
  always_comb begin
    merged_d = '0;
    for (int l = 0; l < 4; l++)
      merged_d[8*l +: 8] = (l >= int'(sv_off_q)) ? beat1_q[8*l +: 8] : lane_dout_i[8*l +: 8];
    load_split_d = extend(rot_right(merged_d, sv_off_q), sv_n_q, sv_signed_q);
  end

  always_comb begin
    lane_addr       = '0;
    lane_write_en_o = '0;
    lane_read_en_o  = '0;
    lane_din_o      = '0;
    if (state_q == SPLIT) begin
      lane_addr  = {word_next, 2'b00};
      lane_din_o = rot_left(sv_wdata_q, sv_off_q);
      if (sv_we_q) lane_write_en_o = sv_mask;
      else         lane_read_en_o  = sv_mask;
    end else if (req_valid_i) begin
      lane_addr  = {req_word, 2'b00};
      lane_din_o = rot_left(req_wdata_i, req_off);
      if (req_we_i) lane_write_en_o = req_mask;
      else          lane_read_en_o  = req_mask;
    end
    if (rst_i) begin
      lane_write_en_o = '0;
      lane_read_en_o  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      sv_we_q     <= 1'b0;
      sv_n_q      <= 3'd1;
      sv_signed_q <= 1'b0;
      sv_off_q    <= '0;
      sv_word_q   <= '0;
      sv_wdata_q  <= '0;
      beat1_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            if (!req_mis) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= req_we_i ? 32'h0 : load_now;
            end else begin
              sv_we_q     <= req_we_i;
              sv_n_q      <= req_n;
              sv_signed_q <= req_signed_i;
              sv_off_q    <= req_off;
              sv_word_q   <= req_word;
              sv_wdata_q  <= req_wdata_i;
              beat1_q     <= lane_dout_i;
              state_q     <= SPLIT;
            end
          end
        end
        default: begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= sv_we_q ? 32'h0 : load_split_d;
          state_q     <= IDLE;
        end
      endcase
    end
  end
`else
  assign req_ready_o = 1'b1;
  assign dbg_state_o = 1'b0;

  // Misaligned requests still present an address but never enable a lane.
  always_comb begin
    lane_addr       = '0;
    lane_write_en_o = '0;
    lane_read_en_o  = '0;
    lane_din_o      = '0;
    if (req_valid_i) begin
      lane_addr  = {req_word, 2'b00};
      lane_din_o = rot_left(req_wdata_i, req_off);
      if (!req_mis && !rst_i) begin
        if (req_we_i) lane_write_en_o = req_mask;
        else          lane_read_en_o  = req_mask;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= req_valid_i;
      rsp_err_q   <= req_valid_i && req_mis;
      if (req_valid_i)
        rsp_data_q <= (req_we_i || req_mis) ? 32'h0 : load_now;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Self-checking bench for dmem_lane_ctrl: directed vector table, corner sequences and random traffic
// checked against a byte-addressed memory model.
module tb_dmem_lane_ctrl;

  localparam int AW    = 13;
  localparam int MEMSZ = 1 << AW;
  localparam int WORDS = MEMSZ / 4;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_MODE = 1'b1;
`else
  localparam bit SPLIT_MODE = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic [AW-1:0] lane_w_addr;
  logic [AW-1:0] lane_r_addr;
  logic [3:0]    lane_wen;
  logic [3:0]    lane_ren;
  logic [31:0]   lane_din;
  logic [31:0]   lane_dout;
  logic          dbg_state;

  dmem_lane_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .lane_w_addr_o(lane_w_addr), .lane_r_addr_o(lane_r_addr),
    .lane_write_en_o(lane_wen), .lane_read_en_o(lane_ren),
    .lane_din_o(lane_din), .lane_dout_i(lane_dout),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / checker ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference memory model ----------------
  logic [7:0] ref_mem [MEMSZ];

  task automatic ref_access(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [AW-1:0] addr, input logic [31:0] wdata,
                            output logic [32:0] r);
    int n;
    int a;
    logic [31:0] v;
    logic sb;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    v = '0;
    if (!SPLIT_MODE && (int'(addr[1:0]) + n > 4)) begin
      r = {1'b1, 32'h0};
      return;
    end
    for (int k = 0; k < n; k++) begin
      a = (int'(addr) + k) % MEMSZ;
      if (we) ref_mem[a] = wdata[8*k +: 8];
      else    v[8*k +: 8] = ref_mem[a];
    end
    sb = sgn && v[8*n-1];
    for (int b = 0; b < 32; b++) if (b >= 8*n) v[b] = sb;
    r = {1'b0, we ? 32'h0 : v};
  endtask

  function automatic logic [3:0] exp_mask1(input logic [1:0] size, input logic [AW-1:0] addr);
    int n;
    int off;
    logic [3:0] m;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr[1:0]);
    m   = '0;
    if (!SPLIT_MODE && off + n > 4) return m;
    for (int k = 0; k < n; k++) if (off + k < 4) m[off + k] = 1'b1;
    return m;
  endfunction

  // ---------------- lane BRAM model (negedge sampled) ----------------
  logic [7:0] lane_mem [4][WORDS];
  logic       mem_load;

  always @(negedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4; i++)
        for (int w = 0; w < WORDS; w++) lane_mem[i][w] <= ref_mem[w*4 + i];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lane_wen[i]) lane_mem[i][lane_w_addr[AW-1:2]] <= lane_din[8*i +: 8];
        if (lane_ren[i]) lane_dout[8*i +: 8] <= lane_mem[i][lane_r_addr[AW-1:2]];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;

  always @(posedge clk) begin
    #1;
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL rsp_unexpected: got data 0x%08h err %0b with no pending request", rsp_data, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_data", rsp_data, mon_e[31:0]);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e[32]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [AW-1:0] addr, input logic [31:0] wdata, input bit push);
    logic [32:0] r;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    if (push) begin
      ref_access(we, size, sgn, addr, wdata, r);
      exp_q.push_back(r);
    end
  endtask

  // Returns #1 after the posedge on which the request was taken.
  task automatic wait_accept();
    int  cyc;
    logic acc;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 8) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!acc) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: got ready=0 for %0d cycles expected acceptance", cyc);
    end
  endtask

  task automatic idle(input int cycles);
    req_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          sgn;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wen;
    logic [3:0]    ren;
    logic [31:0]   din;
    logic [31:0]   rdata;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [32:0] r;
    bit prev_split;
    logic [1:0] rs;
    logic [AW-1:0] ra;
    logic rwe;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 13'h010, 32'hDEADBEEF, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 13'h010, 32'h0,        4'h0, 4'hF, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 13'h013, 32'h00000080, 4'h8, 4'h0, 32'h80000000, 32'h0};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 13'h013, 32'h0,        4'h0, 4'h8, 32'h0,        32'hFFFFFF80};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 13'h013, 32'h0,        4'h0, 4'h8, 32'h0,        32'h00000080};
    tbl[5]  = '{1'b0, 2'd1, 1'b1, 13'h012, 32'h0,        4'h0, 4'hC, 32'h0,        32'hFFFF80AD};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 13'h010, 32'h0,        4'h0, 4'h3, 32'h0,        32'h0000BEEF};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 13'h002, 32'hFFFF1234, 4'hC, 4'h0, 32'h1234FFFF, 32'h0};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 13'h002, 32'h0,        4'h0, 4'hC, 32'h0,        32'h00001234};
    tbl[9]  = '{1'b0, 2'd0, 1'b1, 13'h011, 32'h0,        4'h0, 4'h2, 32'h0,        32'hFFFFFFBE};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 13'h1FFC, 32'h01234567, 4'hF, 4'h0, 32'h01234567, 32'h0};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 13'h1FFC, 32'h0,       4'h0, 4'hF, 32'h0,        32'h01234567};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 13'h010, 32'h0,        4'h0, 4'hF, 32'h0,        32'h80ADBEEF};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int a = 0; a < MEMSZ; a++) ref_mem[a] = 8'($urandom_range(0, 255));
    mem_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    mem_load = 1'b0;

    // Reset state, with a live request that must not enable any lane.
    drive_req(1'b1, 2'd2, 1'b0, 13'h040, 32'h55AA55AA, 1'b0);
    #1;
    chk("rst_wen", 32'(lane_wen), 32'h0);
    chk("rst_ren", 32'(lane_ren), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 13; i++) begin
      drive_req(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, 1'b0);
      ref_access(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, r);
      exp_q.push_back({1'b0, tbl[i].rdata});
      #1;
      chk("tbl_wen", 32'(lane_wen), 32'(tbl[i].wen));
      chk("tbl_ren", 32'(lane_ren), 32'(tbl[i].ren));
      chk("tbl_waddr", 32'(lane_w_addr), 32'(tbl[i].addr & 13'h1FFC));
      chk("tbl_raddr", 32'(lane_r_addr), 32'(tbl[i].addr & 13'h1FFC));
      chk("tbl_din", lane_din, tbl[i].din);
      wait_accept();
    end
    idle(3);

`ifdef MISALIGN_SPLIT_EN
    // Misaligned half store crossing 0x017/0x018.
    drive_req(1'b1, 2'd1, 1'b0, 13'h017, 32'h0000A1B2, 1'b1);
    #1;
    chk("split_b1_wen", 32'(lane_wen), 32'h8);
    chk("split_b1_addr", 32'(lane_w_addr), 32'h014);
    chk("split_b1_lane3", 32'(lane_din[31:24]), 32'hB2);
    chk("split_b1_ready", 32'(req_ready), 32'h1);
    wait_accept();
    chk("split_b2_wen", 32'(lane_wen), 32'h1);
    chk("split_b2_addr", 32'(lane_w_addr), 32'h018);
    chk("split_b2_lane0", 32'(lane_din[7:0]), 32'hA1);
    chk("split_b2_ready", 32'(req_ready), 32'h0);
    exp_q.push_back({1'b0, 32'h0000A1B2});
    drive_req(1'b0, 2'd1, 1'b0, 13'h017, 32'h0, 1'b0);
    wait_accept();
    idle(3);

    // Word load at the top address wraps beat 2 to word 0.
    drive_req(1'b0, 2'd2, 1'b0, 13'h1FFE, 32'h0, 1'b1);
    #1;
    chk("wrap_b1_ren", 32'(lane_ren), 32'hC);
    chk("wrap_b1_addr", 32'(lane_r_addr), 32'h1FFC);
    wait_accept();
    chk("wrap_b2_ren", 32'(lane_ren), 32'h3);
    chk("wrap_b2_addr", 32'(lane_r_addr), 32'h000);
    idle(3);
    chk("drain_before_rst", 32'(exp_q.size()), 32'h0);

    // Reset while in beat 2 of a store: only the beat-1 bytes land.
    drive_req(1'b1, 2'd2, 1'b0, 13'h021, 32'h11223344, 1'b0);
    wait_accept();
    rst = 1'b1;
    #1;
    chk("rst_split_ready", 32'(req_ready), 32'h1);
    chk("rst_split_wen", 32'(lane_wen), 32'h0);
    chk("rst_split_ren", 32'(lane_ren), 32'h0);
    chk("rst_split_rsp_valid", 32'(rsp_valid), 32'h0);
    ref_mem[13'h021] = 8'h44;
    ref_mem[13'h022] = 8'h33;
    ref_mem[13'h023] = 8'h22;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    drive_req(1'b0, 2'd2, 1'b0, 13'h020, 32'h0, 1'b1);
    wait_accept();
    drive_req(1'b0, 2'd0, 1'b0, 13'h024, 32'h0, 1'b1);
    wait_accept();
    idle(2);
`else
    // Misaligned requests are rejected without touching the lanes.
    drive_req(1'b0, 2'd2, 1'b0, 13'h001, 32'h0, 1'b1);
    #1;
    chk("rej_word_wen", 32'(lane_wen), 32'h0);
    chk("rej_word_ren", 32'(lane_ren), 32'h0);
    wait_accept();
    chk("rej_word_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rej_word_rsp_err", 32'(rsp_err), 32'h1);
    chk("rej_word_rsp_data", rsp_data, 32'h0);
    drive_req(1'b1, 2'd1, 1'b0, 13'h017, 32'h0000A1B2, 1'b1);
    #1;
    chk("rej_half_wen", 32'(lane_wen), 32'h0);
    chk("rej_half_ready", 32'(req_ready), 32'h1);
    wait_accept();
    drive_req(1'b0, 2'd2, 1'b0, 13'h1FFE, 32'h0, 1'b1);
    #1;
    chk("rej_top_ren", 32'(lane_ren), 32'h0);
    wait_accept();
    idle(2);
    chk("drain_before_rst", 32'(exp_q.size()), 32'h0);

    // Reset with a live request: enables drop and no response appears.
    drive_req(1'b1, 2'd2, 1'b0, 13'h020, 32'h11223344, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_live_wen", 32'(lane_wen), 32'h0);
    chk("rst_live_rsp_valid", 32'(rsp_valid), 32'h0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
`endif

    // Back-to-back aligned loads: one response every cycle.
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b0, 2'd2, 1'b0, AW'(32'h040 + 4*i), 32'h0, 1'b1);
      wait_accept();
      chk("b2b_rsp_valid", 32'(rsp_valid), 32'h1);
    end
    idle(3);

    // Random traffic against the byte-addressed model.
    prev_split = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
        prev_split = 1'b0;
      end else begin
        rwe = 1'($urandom_range(0, 1));
        rs  = 2'($urandom_range(0, 3));
        ra  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(MEMSZ - 4, MEMSZ - 1))
                                          : AW'($urandom_range(0, MEMSZ - 1));
        drive_req(rwe, rs, 1'($urandom_range(0, 1)), ra, $urandom, 1'b1);
        #1;
        if (!prev_split) begin
          chk("rnd_en", {24'h0, lane_wen, lane_ren},
              rwe ? {24'h0, exp_mask1(rs, ra), 4'h0} : {24'h0, 4'h0, exp_mask1(rs, ra)});
          chk("rnd_addr", 32'(lane_r_addr), 32'(ra & 13'h1FFC));
        end
        prev_split = SPLIT_MODE && (exp_mask1(rs, ra) != lane_mask_full(rs, ra));
        wait_accept();
      end
    end

    idle(5);
    chk("final_drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Set of all lanes an access touches; differs from the beat-1 set exactly when it splits.
  function automatic logic [3:0] lane_mask_full(input logic [1:0] size, input logic [AW-1:0] addr);
    int n;
    logic [3:0] m;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    m = '0;
    for (int k = 0; k < n; k++) m[(int'(addr[1:0]) + k) % 4] = 1'b1;
    return m;
  endfunction

endmodule
